// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: drives the PC register write/hold and folds
// jump/branch redirects that arrive while the PC cannot advance.
//
// state | meaning
// IDLE  | not running; next_pc parked at RESET_PC, stall count cleared
// FETCH | fetch request outstanding at pc_i; PC advances on ack
// HOLD  | fetch accepted but a hazard blocks the PC from advancing
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             imem_ack,
  input  logic [31:0]      pc_i,
  output logic             imem_req,
  output logic             pc_we,
  output logic             pc_stall,
  output logic [31:0]      next_pc,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t      state, state_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic        pend_jmp, pend_jmp_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic        cnt_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pend_vld <= 1'b0;
      pend_jmp <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      pend_vld <= pend_vld_nxt;
      pend_jmp <= pend_jmp_nxt;
      pend_tgt <= pend_tgt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    imem_req     = 1'b0;
    pc_we        = 1'b0;
    pend_vld_nxt = pend_vld;
    pend_jmp_nxt = pend_jmp;
    pend_tgt_nxt = pend_tgt;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (hazard_stall) state_nxt = HOLD;
          else              pc_we     = 1'b1;
        end
      end
      HOLD: begin
        if (!hazard_stall) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase

    if (!start) begin
      state_nxt = IDLE;
      pc_we     = 1'b0;
    end

    pc_stall = (state != IDLE) && !pc_we;
    flush    = pc_we && (jump || branch_taken || pend_vld);

    if (state == IDLE)     next_pc = RESET_PC;
    else if (!pc_we)       next_pc = pc_i;
    else if (jump)         next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
    else if (pend_vld)     next_pc = pend_tgt;
    else                   next_pc = pc_i + PC_INC;

    // A parked jump is never displaced by a later branch; any PC write retires the slot.
    if (!start || pc_we) begin
      pend_vld_nxt = 1'b0;
      pend_jmp_nxt = 1'b0;
    end else if (jump) begin
      pend_vld_nxt = 1'b1;
      pend_jmp_nxt = 1'b1;
      pend_tgt_nxt = jump_target;
    end else if (branch_taken && !(pend_vld && pend_jmp)) begin
      pend_vld_nxt = 1'b1;
      pend_jmp_nxt = 1'b0;
      pend_tgt_nxt = branch_target;
    end
  end

  assign cnt_clr = (state == IDLE) || !start;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a cycle-level model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          CW     = 16;
  localparam int          CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, hazard_stall, branch_taken, jump, imem_ack;
  logic [31:0]   branch_target, jump_target, pc_i;
  logic          imem_req, pc_we, pc_stall, flush;
  logic [31:0]   next_pc;
  logic [CW-1:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  // model: running / blocked-by-hazard flags, parked redirect, stall tally
  bit          m_run, m_blk, m_pv, m_pj;
  logic [31:0] m_pt;
  int          m_cnt;
  logic [31:0] pc_reg;
  bit          e_we, e_req, e_stall, e_flush;
  logic [31:0] e_npc;

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_ack(imem_ack), .pc_i(pc_i),
    .imem_req(imem_req), .pc_we(pc_we), .pc_stall(pc_stall),
    .next_pc(next_pc), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_blk = 0; m_pv = 0; m_pj = 0; m_pt = '0; m_cnt = 0;
  endtask

  // apply inputs, wait for the falling edge, compare against the model
  task automatic drive(input logic s, input logic hz, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic ack);
    start = s; hazard_stall = hz; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; imem_ack = ack; pc_i = pc_reg;
    @(negedge clk);
    e_req   = m_run && !m_blk;
    e_we    = e_req && ack && !hz && s;
    e_stall = m_run && !e_we;
    e_flush = e_we && (j || br || m_pv);
    if (!m_run)    e_npc = RST_PC;
    else if (j)    e_npc = jt;
    else if (br)   e_npc = bt;
    else if (m_pv) e_npc = m_pt;
    else           e_npc = pc_reg + 32'd4;
    chk("imem_req", imem_req, e_req);
    chk("pc_we", pc_we, e_we);
    chk("pc_stall", pc_stall, e_stall);
    chk("flush", flush, e_flush);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (!m_run || e_we) chk("next_pc", next_pc, e_npc);
  endtask

  // advance the model and the bench PC register across the rising edge
  task automatic advance();
    if (!start) begin
      m_run = 0; m_blk = 0; m_pv = 0; m_pj = 0; m_cnt = 0;
    end else begin
      if (!m_run) m_cnt = 0;
      else if (e_stall) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (e_we) m_pv = 0;
      else if (jump) begin m_pv = 1; m_pj = 1; m_pt = jump_target; end
      else if (branch_taken && !(m_pv && m_pj)) begin m_pv = 1; m_pj = 0; m_pt = branch_target; end
      if (!m_run) begin m_run = 1; m_blk = 0; end
      else if (m_blk) m_blk = hazard_stall;
      else if (imem_ack && hazard_stall) m_blk = 1;
    end
    if (e_we) pc_reg = e_npc;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic hz, input logic ack);
    drive(s, hz, 1'b0, 32'h0, 1'b0, 32'h0, ack);
    advance();
  endtask

  initial begin
    rst = 1'b0; pc_reg = RST_PC;
    start = 0; hazard_stall = 0; branch_taken = 0; jump = 0; imem_ack = 0;
    branch_target = '0; jump_target = '0; pc_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_we", pc_we, 1'b0);
    chk("rst_stall", pc_stall, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_npc", next_pc, RST_PC);
    rst = 1'b1;

    // straight-line fetch: 0,4,8,12
    step(1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 0, 1);
      chk("seq_pc", pc_i, k * 4);
      chk("seq_flush", flush, 1'b0);
      advance();
    end

    // simultaneous jump and branch
    pc_reg = 32'h100;
    drive(1, 0, 1, 32'h200, 1, 32'h300, 1);
    chk("jb_npc", next_pc, 32'h300);
    chk("jb_flush", flush, 1'b1);
    advance();
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("jb_flush_off", flush, 1'b0);
    advance();

    // wrap at top of address space
    pc_reg = 32'hFFFF_FFFC;
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("wrap_npc", next_pc, 32'h0);
    advance();

    // branch parked during an ack gap
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    drive(1, 0, 1, 32'h40, 0, 0, 0);
    advance();
    step(1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("pend_we", pc_we, 1'b1);
    chk("pend_npc", next_pc, 32'h40);
    chk("pend_flush", flush, 1'b1);
    chk("pend_cnt", stall_cnt, 3);
    advance();

    // hazard moves into HOLD
    step(1, 1, 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("hold_stall", pc_stall, 1'b1);
    chk("hold_req", imem_req, 1'b0);
    advance();
    step(1, 0, 0);

    // parked jump dropped by stop, restart is sequential
    drive(1, 0, 0, 0, 1, 32'h500, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("stop_we", pc_we, 1'b0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("stop_cnt", stall_cnt, 0);
    advance();
    step(1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("restart_npc", next_pc, pc_reg + 32'd4);
    chk("restart_flush", flush, 1'b0);
    advance();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) pc_reg = {$urandom(), 2'b00} >> 0;
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom_range(0, 7) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
            $urandom_range(0, 2) != 0);
      advance();
    end

    // reset mid-fetch, ack while in reset ignored
    step(0, 0, 0);
    step(1, 0, 0);
    start = 1; imem_ack = 1; hazard_stall = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_we", pc_we, 1'b0);
    chk("arst_npc", next_pc, RST_PC);
    chk("arst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_req", imem_req, 1'b0);
    chk("arst_hold_flush", flush, 1'b0);
    rst = 1'b1;
    model_reset();
    step(1, 0, 1);
    step(1, 0, 1);

    // stall counter saturation
    step(0, 0, 0);
    step(1, 1, 1);
    for (int n = 0; n < CMAX + 5; n++) step(1, 1, 1);
    drive(1, 1, 0, 0, 0, 0, 1);
    chk("sat_cnt", stall_cnt, 16'hFFFF);
    chk("sat_stall", pc_stall, 1'b1);
    advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: next_pc value while idle or in reset.
REQ-002 Parameter CNT_W, default 16: stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run enable; 0 forces IDLE.
REQ-006 hazard_stall  input  1  pipeline hazard; PC must not advance.
REQ-007 branch_taken  input  1  one-cycle pulse; redirect to branch_target.
REQ-008 branch_target  input  32  branch destination.
REQ-009 jump  input  1  one-cycle pulse; redirect to jump_target.
REQ-010 jump_target  input  32  jump destination.
REQ-011 imem_ack  input  1  instruction memory accepted the current fetch.
REQ-012 pc_i  input  32  current PC register value.
REQ-013 imem_req  output  1  fetch request at pc_i.
REQ-014 pc_we  output  1  PC register write enable.
REQ-015 pc_stall  output  1  PC register hold.
REQ-016 next_pc  output  32  value to load into the PC register.
REQ-017 flush  output  1  one-cycle pulse; squash the wrong-path instruction.
REQ-018 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, HOLD; reset state IDLE.
REQ-020 IDLE: imem_req=0, pc_we=0, pc_stall=0, next_pc=RESET_PC; start=1 -> FETCH next cycle.
REQ-021 FETCH: imem_req=1; imem_ack=1 and hazard_stall=0 -> pc_we=1, stay FETCH; imem_ack=1 and hazard_stall=1 -> HOLD; imem_ack=0 -> stay FETCH.
REQ-022 HOLD: imem_req=0, pc_we=0; hazard_stall=0 -> FETCH next cycle.
REQ-023 pc_stall SHALL be 1 exactly when state is not IDLE and pc_we=0.
REQ-024 pc_we SHALL be combinational from current state and inputs (zero added latency); PC updates on the same edge.
REQ-025 next_pc priority when pc_we=1: live jump > live branch_taken > pending redirect > pc_i+4.
REQ-026 pc_i+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 A jump/branch pulse in a cycle with pc_we=0 SHALL be latched into a pending-redirect register (valid + 32-bit target).
REQ-028 A later jump overwrites a pending branch; a later branch SHALL NOT overwrite a pending jump.
REQ-029 Simultaneous jump and branch_taken: jump wins, branch discarded.
REQ-030 Pending redirect SHALL clear on the cycle it is consumed (pc_we=1).
REQ-031 flush SHALL be 1 for exactly the cycle a redirect (live or pending) is applied with pc_we=1; otherwise 0.
REQ-032 stall_cnt SHALL increment each cycle pc_stall=1, saturate at all-ones, and clear to 0 while in IDLE.
REQ-033 start falling in any state SHALL move to IDLE next cycle, drop pending redirect, pc_we=0 in that cycle.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, pending valid=0, stall_cnt=0, flush=0, pc_we=0, imem_req=0, pc_stall=0, next_pc=RESET_PC.
REQ-035 Reset assertion mid-fetch SHALL discard any outstanding request; imem_ack during reset is ignored.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enum (IDLE, FETCH, HOLD) and PC_INC=32'd4.
REQ-037 Stall counter SHALL be a separate sub-module sat_counter (parameter width; inc, clr; async active-low reset).

Verification
REQ-038 Reset, start=1, imem_ack=1 every cycle, pc_i tracking next_pc -> pc_i sequence 0,4,8,12; flush=0 throughout.
REQ-039 pc_i=0x100, branch_taken=1 with target 0x200 and jump=1 with target 0x300 in the same cycle -> next_pc=0x300, flush=1 for one cycle.
REQ-040 imem_ack=0 for 3 cycles, branch pulse (target 0x40) in the 2nd cycle, then ack=1 -> pc_we=1 with next_pc=0x40, flush=1, stall_cnt=3.
REQ-041 pc_i=0xFFFF_FFFC, ack=1, no redirect -> next_pc=0x0000_0000.
REQ-042 hazard_stall=1 with ack=1 -> HOLD, pc_stall=1, imem_req=0; counter saturates at 0xFFFF after 65535+ stalled cycles with CNT_W=16.
REQ-043 Pending jump, then start=0 -> IDLE next cycle, pending cleared, stall_cnt=0; restart yields next_pc=pc_i+4 and no flush.
